nn_rnn_sched: RTL

- Sequencing controller for the NN recurrent-cell datapath.
- Counts the serial operand load, then schedules one shared, pipelined FP32 multiply-accumulate unit over each time step: h_t = ReLU(U·x_t + W·h_{t-1}) and y_t = sigmoid(V·h_t).
- Handles the ping-pong hidden-state banks and the result write-back.
- Streams all y values out at the end. Operand storage, the MAC and the activations live in the datapath; this block drives only indices and strobes.

---
 rtl/nn_rnn_sched.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nn_rnn_sched.sv
// Sequencer for the recurrent-cell datapath: counts the operand load, issues
// U/W/V products to a shared pipelined MAC, tracks write-backs, streams Y out.
module nn_rnn_sched #(
   parameter int DIM     = 3,
   parameter int STEPS   = 3,
   parameter int MAC_LAT = 3,
   parameter int IW      = $clog2(DIM*DIM)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          ld_en,
   output logic [IW-1:0] ld_idx,
   output logic          mac_issue,
   output logic          mac_first,
   output logic          mac_last,
   output logic [1:0]    mac_a_mat,
   output logic [IW-1:0] mac_a_idx,
   output logic [1:0]    mac_b_src,
   output logic [IW-1:0] mac_b_idx,
   output logic          wb_en,
   output logic [1:0]    wb_dst,
   output logic [IW-1:0] wb_idx,
   output logic          wb_act,
   output logic          out_valid,
   output logic [IW-1:0] out_idx,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_H_ISS,
      S_DRAIN,
      S_Y_ISS,
      S_FDRAIN,
      S_OUT
   } state_t;

   typedef struct packed {
      logic          last;
      logic [1:0]    dst;
      logic [IW-1:0] idx;
      logic          act;
   } wb_t;

   localparam logic [1:0] MAT_U   = 2'd0;
   localparam logic [1:0] MAT_W   = 2'd1;
   localparam logic [1:0] MAT_V   = 2'd2;
   localparam logic [1:0] SRC_X   = 2'd0;
   localparam logic [1:0] SRC_H0  = 2'd1;
   localparam logic [1:0] SRC_H1  = 2'd2;
   localparam logic [1:0] DST_Y   = 2'd3;

   localparam logic [IW-1:0] DIM_I    = IW'(DIM);
   localparam logic [IW-1:0] LAST_LD  = IW'(DIM*DIM - 1);
   localparam logic [IW-1:0] LAST_KH  = IW'(2*DIM - 1);
   localparam logic [IW-1:0] LAST_KY  = IW'(DIM - 1);
   localparam logic [IW-1:0] LAST_ROW = IW'(DIM - 1);
   localparam logic [IW-1:0] LAST_T   = IW'(STEPS - 1);
   localparam logic [IW-1:0] LAST_OUT = IW'(STEPS*DIM - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   ld_cnt_q, ld_cnt_d;
   logic [IW-1:0]   out_cnt_q, out_cnt_d;
   logic [IW-1:0]   t_q, t_d;
   logic [IW-1:0]   row_q, row_d;
   logic [IW-1:0]   k_q, k_d;
   wb_t             pipe_q [MAC_LAT];
   wb_t             push_d;
   wb_t             wb_head;
   logic            ld_en_c;

   assign wb_head = pipe_q[MAC_LAT-1];

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      out_cnt_d = out_cnt_q;
      t_d       = t_q;
      row_d     = row_q;
      k_d       = k_q;
      ld_en_c   = 1'b0;
      ld_idx    = '0;
      mac_issue = 1'b0;
      mac_first = 1'b0;
      mac_last  = 1'b0;
      mac_a_mat = MAT_U;
      mac_a_idx = '0;
      mac_b_src = SRC_X;
      mac_b_idx = '0;
      push_d    = '0;
      out_valid = 1'b0;
      out_idx   = '0;

      case (state_q)
         S_IDLE, S_LOAD: begin
            ld_en_c = in_valid;
            ld_idx  = ld_cnt_q;
            if (in_valid) begin
               if (ld_cnt_q == LAST_LD) begin
                  ld_cnt_d = '0;
                  t_d      = '0;
                  row_d    = '0;
                  k_d      = '0;
                  state_d  = S_H_ISS;
               end else begin
                  ld_cnt_d = ld_cnt_q + 1'b1;
                  state_d  = S_LOAD;
               end
            end
         end

         S_H_ISS: begin
            mac_issue = 1'b1;
            mac_first = (k_q == '0);
            mac_last  = (k_q == LAST_KH);
            if (k_q < DIM_I) begin
               mac_a_mat = MAT_U;
               mac_a_idx = row_q * DIM_I + k_q;
               mac_b_src = SRC_X;
               mac_b_idx = t_q * DIM_I + k_q;
            end else begin
               mac_a_mat = MAT_W;
               mac_a_idx = row_q * DIM_I + (k_q - DIM_I);
               mac_b_src = t_q[0] ? SRC_H1 : SRC_H0;
               mac_b_idx = k_q - DIM_I;
            end
            // h_{t+1} goes to the bank that h_t is not being read from
            if (mac_last) begin
               push_d.last = 1'b1;
               push_d.dst  = t_q[0] ? SRC_H0 : SRC_H1;
               push_d.idx  = row_q;
               push_d.act  = 1'b0;
               k_d         = '0;
               if (row_q == LAST_ROW) begin
                  row_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         S_DRAIN: begin
            if (wb_head.last && (wb_head.dst != DST_Y) && (wb_head.idx == LAST_ROW))
               state_d = S_Y_ISS;
         end

         S_Y_ISS: begin
            mac_issue = 1'b1;
            mac_first = (k_q == '0);
            mac_last  = (k_q == LAST_KY);
            mac_a_mat = MAT_V;
            mac_a_idx = row_q * DIM_I + k_q;
            mac_b_src = t_q[0] ? SRC_H0 : SRC_H1;
            mac_b_idx = k_q;
            if (mac_last) begin
               push_d.last = 1'b1;
               push_d.dst  = DST_Y;
               push_d.idx  = t_q * DIM_I + row_q;
               push_d.act  = 1'b1;
               k_d         = '0;
               if (row_q == LAST_ROW) begin
                  row_d = '0;
                  // V·h_t and the next step's products are independent
                  if (t_q < LAST_T) begin
                     t_d     = t_q + 1'b1;
                     state_d = S_H_ISS;
                  end else begin
                     state_d = S_FDRAIN;
                  end
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         S_FDRAIN: begin
            if (wb_head.last && (wb_head.dst == DST_Y) && (wb_head.idx == LAST_OUT)) begin
               out_cnt_d = '0;
               state_d   = S_OUT;
            end
         end

         S_OUT: begin
            out_valid = 1'b1;
            out_idx   = out_cnt_q;
            if (out_cnt_q == LAST_OUT) begin
               out_cnt_d = '0;
               t_d       = '0;
               state_d   = S_IDLE;
            end else begin
               out_cnt_d = out_cnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ld_cnt_q  <= '0;
         out_cnt_q <= '0;
         t_q       <= '0;
         row_q     <= '0;
         k_q       <= '0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         out_cnt_q <= out_cnt_d;
         t_q       <= t_d;
         row_q     <= row_d;
         k_q       <= k_d;
      end
   end

   // NOTE: the write-back pipeline is reset (it is only MAC_LAT entries), so
   // an aborted job can never emit a stale wb_en after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAC_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= push_d;
         for (int i = 1; i < MAC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign ld_en  = ld_en_c & rst_n;
   assign wb_en  = wb_head.last;
   assign wb_dst = wb_head.dst;
   assign wb_idx = wb_head.idx;
   assign wb_act = wb_head.act;
   assign busy   = (state_q != S_IDLE);

endmodule
